// File: rtl/cblock_cfg_param_if.sv
// ============================================================================
// Module  : cblock_cfg_param_if
// Brief   : Configuration load handshake bundle for cblock_cfg_param.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

interface cblock_cfg_param_if #(
  parameter int CFG_WORD = 8
) ();
  logic                cfg_start;
  logic                cfg_abort;
  logic                cfg_valid;
  logic [CFG_WORD-1:0] cfg_data;
  logic                cfg_ready;
  logic                cfg_busy;
  logic                cfg_done;
  logic                cfg_err;

  modport master (
    output cfg_start, cfg_abort, cfg_valid, cfg_data,
    input  cfg_ready, cfg_busy, cfg_done, cfg_err
  );

  modport slave (
    input  cfg_start, cfg_abort, cfg_valid, cfg_data,
    output cfg_ready, cfg_busy, cfg_done, cfg_err
  );
endinterface

`default_nettype wire

// File: rtl/cblock_cfg_param.sv
// ============================================================================
// Module  : cblock_cfg_param
// Brief   : Connection block, W tracks to one pin column, shadow/active config.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module cblock_cfg_param #(
  parameter int W        = 3,
  parameter int CFG_WORD = 8
) (
  input  wire logic         clk,
  input  wire logic         rst_n,
  cblock_cfg_param_if.slave cfg,
  input  wire logic [W-1:0] left_i,
  output logic      [W-1:0] right_o,
  input  wire logic         up_i,
  input  wire logic         down_i,
  output logic              up_o,
  output logic              up_oe,
  output logic              down_o,
  output logic              down_oe
);

  localparam int SW       = $clog2(W + 2);
  localparam int CFG_BITS = 2 * SW + 2 * W;
  localparam int NWORDS   = (CFG_BITS + CFG_WORD - 1) / CFG_WORD;
  localparam int CW       = $clog2(NWORDS + 1);
  localparam logic [CW-1:0] C_LAST = CW'(NWORDS - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOAD   = 2'd1,
    S_COMMIT = 2'd2
  } state_e;

  state_e              state_q;
  logic [CW-1:0]       word_cnt_q;
  logic [CFG_BITS-1:0] shadow_q;
  logic [CFG_BITS-1:0] active_q;
  logic                ready_q;
  logic                busy_q;
  logic                done_q;
  logic                err_q;

  logic [SW-1:0] w_sh_up_sel;
  logic [SW-1:0] w_sh_dn_sel;
  logic          w_sh_legal;
  logic [SW-1:0] w_up_sel;
  logic [SW-1:0] w_dn_sel;

  assign w_sh_up_sel = shadow_q[SW-1:0];
  assign w_sh_dn_sel = shadow_q[2*SW-1:SW];
  assign w_sh_legal  = (int'(w_sh_up_sel) <= W + 1) && (int'(w_sh_dn_sel) <= W + 1);

  assign cfg.cfg_ready = ready_q;
  assign cfg.cfg_busy  = busy_q;
  assign cfg.cfg_done  = done_q;
  assign cfg.cfg_err   = err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      word_cnt_q <= '0;
      shadow_q   <= '0;
      active_q   <= '0;
      ready_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (cfg.cfg_start) begin
            state_q    <= S_LOAD;
            word_cnt_q <= '0;
            ready_q    <= 1'b1;
            busy_q     <= 1'b1;
          end
        end
        S_LOAD: begin
          // Abort wins over a word offered in the same cycle.
          if (cfg.cfg_abort) begin
            state_q    <= S_IDLE;
            word_cnt_q <= '0;
            shadow_q   <= '0;
            ready_q    <= 1'b0;
            busy_q     <= 1'b0;
          end else if (cfg.cfg_valid) begin
            for (int b = 0; b < CFG_BITS; b++) begin
              if (word_cnt_q == CW'(b / CFG_WORD)) begin
                shadow_q[b] <= cfg.cfg_data[b % CFG_WORD];
              end
            end
            if (word_cnt_q == C_LAST) begin
              state_q <= S_COMMIT;
              ready_q <= 1'b0;
            end else begin
              word_cnt_q <= word_cnt_q + 1'b1;
            end
          end
        end
        S_COMMIT: begin
          if (w_sh_legal) begin
            active_q <= shadow_q;
            done_q   <= 1'b1;
          end else begin
            err_q <= 1'b1;
          end
          state_q    <= S_IDLE;
          word_cnt_q <= '0;
          busy_q     <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          ready_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign w_up_sel = active_q[SW-1:0];
  assign w_dn_sel = active_q[2*SW-1:SW];

  // Selector 0 disables the driver, 1..W taps a track, W+1 passes the opposite vertical.
  always_comb begin
    up_oe   = (w_up_sel != '0);
    down_oe = (w_dn_sel != '0);
    up_o    = 1'b0;
    down_o  = 1'b0;
    for (int k = 1; k <= W; k++) begin
      if (int'(w_up_sel) == k) up_o   = left_i[k-1];
      if (int'(w_dn_sel) == k) down_o = left_i[k-1];
    end
    if (int'(w_up_sel) == W + 1) up_o   = down_i;
    if (int'(w_dn_sel) == W + 1) down_o = up_i;
  end

  generate
    for (genvar i = 0; i < W; i++) begin : g_right
      logic [1:0] w_rsel;
      assign w_rsel     = active_q[2*SW+2*i +: 2];
      assign right_o[i] = (w_rsel == 2'b01) ? up_i   :
                          (w_rsel == 2'b10) ? down_i : left_i[i];
    end
  endgenerate

endmodule

`default_nettype wire

// File: tb/tb_cblock_cfg_param.sv
// ============================================================================
// Module  : tb_cblock_cfg_param
// Brief   : Randomised self-checking bench with a behavioural routing model.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_cblock_cfg_param;

  localparam int W  = 3;
  localparam int CW = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] left_i;
  logic [2:0] right_o;
  logic       up_i, down_i, up_o, up_oe, down_o, down_oe;
  logic [6:0] obs;

  int total = 0;
  int bad   = 0;
  logic [11:0] model_cfg;

  always #5 clk = ~clk;

  cblock_cfg_param_if #(.CFG_WORD(CW)) cif ();

  cblock_cfg_param #(.W(W), .CFG_WORD(CW)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .cfg     (cif.slave),
    .left_i  (left_i),
    .right_o (right_o),
    .up_i    (up_i),
    .down_i  (down_i),
    .up_o    (up_o),
    .up_oe   (up_oe),
    .down_o  (down_o),
    .down_oe (down_oe)
  );

  assign obs = {up_oe, up_o, down_oe, down_o, right_o};

  // Expected {up_oe, up_o, down_oe, down_o, right_o} from a 12-bit config image.
  function automatic logic [6:0] model_route(logic [11:0] c, logic [2:0] l, logic u, logic d);
    int us, ds, r;
    logic uo, uoe, dno, dnoe;
    logic [2:0] rt;
    us   = int'(c) % 8;
    ds   = (int'(c) / 8) % 8;
    uoe  = (us != 0);
    dnoe = (ds != 0);
    uo   = 1'b0;
    dno  = 1'b0;
    if (us >= 1 && us <= W) uo = l[us-1];
    else if (us == W + 1)   uo = d;
    if (ds >= 1 && ds <= W) dno = l[ds-1];
    else if (ds == W + 1)   dno = u;
    for (int i = 0; i < W; i++) begin
      r = (int'(c) >> (6 + 2 * i)) % 4;
      rt[i] = (r == 1) ? u : (r == 2) ? d : l[i];
    end
    return {uoe, uo, dnoe, dno, rt};
  endfunction

  function automatic bit model_legal(logic [11:0] c);
    return ((int'(c) % 8) <= W + 1) && (((int'(c) / 8) % 8) <= W + 1);
  endfunction

  // Drives one complete load; mode 0 = always valid, 1 = valid 1,0,0,1, 2 = random.
  task automatic run_load(input logic [7:0] w0, input logic [7:0] w1, input int mode,
                          output int n_done, output int n_err, output int n_acc,
                          output int cyc, output int lat);
    int idx;
    bit acc;
    idx = 0; cyc = 0; n_acc = 0;
    cif.cfg_start = 1'b1;
    @(posedge clk); #1;
    cif.cfg_start = (mode == 2) ? 1'($urandom % 2) : 1'b0;
    while (idx < 2 && cyc < 40) begin
      case (mode)
        0:       cif.cfg_valid = 1'b1;
        1:       cif.cfg_valid = (cyc % 4 == 0) || (cyc % 4 == 3);
        default: cif.cfg_valid = 1'($urandom % 2);
      endcase
      cif.cfg_data = (idx == 0) ? w0 : w1;
      @(negedge clk);
      acc = cif.cfg_valid && cif.cfg_ready;
      @(posedge clk); #1;
      if (acc) begin idx++; n_acc++; end
      cyc++;
    end
    cif.cfg_valid = 1'b0;
    cif.cfg_start = 1'b0;
    lat = -1; n_done = 0; n_err = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if ((cif.cfg_done || cif.cfg_err) && lat < 0) lat = c;
      n_done += int'(cif.cfg_done);
      n_err  += int'(cif.cfg_err);
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    left_i = 3'b101; up_i = 1'b0; down_i = 1'b1;
    cif.cfg_start = 0; cif.cfg_abort = 0; cif.cfg_valid = 0; cif.cfg_data = '0;
    model_cfg = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    total++; if (right_o !== 3'b101) begin bad++; $display("FAIL reset_right got=%b want=101", right_o); end
    total++; if ({up_oe, down_oe, up_o, down_o} !== 4'b0000) begin bad++; $display("FAIL reset_vert got=%b want=0000", {up_oe, down_oe, up_o, down_o}); end
    total++; if ({cif.cfg_ready, cif.cfg_busy, cif.cfg_done, cif.cfg_err} !== 4'b0000) begin bad++;
      $display("FAIL reset_status got=%b want=0000", {cif.cfg_ready, cif.cfg_busy, cif.cfg_done, cif.cfg_err}); end
    @(posedge clk); #1;
  endtask

  task automatic test_illegal;
    int nd, ne, na, cy, lt;
    run_load(8'h32, 8'h06, 0, nd, ne, na, cy, lt);
    total++; if (ne !== 1 || nd !== 0) begin bad++; $display("FAIL illegal_pulses got done=%0d err=%0d want done=0 err=1", nd, ne); end
    total++; if (lt !== 1) begin bad++; $display("FAIL illegal_latency got=%0d want=1", lt); end
    left_i = 3'b110; up_i = 1'b1; down_i = 1'b0; #1;
    total++; if (obs !== model_route(model_cfg, left_i, up_i, down_i)) begin bad++;
      $display("FAIL illegal_routing got=%b want=%b", obs, model_route(model_cfg, left_i, up_i, down_i)); end
  endtask

  task automatic test_legal;
    int nd, ne, na, cy, lt;
    run_load(8'h22, 8'h06, 0, nd, ne, na, cy, lt);
    model_cfg = 12'h622;
    total++; if (nd !== 1 || ne !== 0) begin bad++; $display("FAIL legal_pulses got done=%0d err=%0d want done=1 err=0", nd, ne); end
    total++; if (lt !== 1) begin bad++; $display("FAIL legal_latency got=%0d want=1", lt); end
    left_i = 3'b010; up_i = 1'b1; down_i = 1'b0; #1;
    total++; if (obs !== model_route(model_cfg, left_i, up_i, down_i)) begin bad++;
      $display("FAIL legal_routing got=%b want=%b", obs, model_route(model_cfg, left_i, up_i, down_i)); end
  endtask

  task automatic test_back_to_back;
    int nd, ne, na, cy, lt;
    logic [11:0] c;
    c = 12'($urandom_range(0, 4095));
    c[2:0] = 3'($urandom_range(0, 4));
    c[5:3] = 3'($urandom_range(0, 4));
    run_load(c[7:0], {4'($urandom), c[11:8]}, 1, nd, ne, na, cy, lt);
    model_cfg = c;
    total++; if (na !== 2 || cy !== 4) begin bad++; $display("FAIL bp_words got acc=%0d cycles=%0d want acc=2 cycles=4", na, cy); end
    total++; if (nd !== 1 || lt !== 1) begin bad++; $display("FAIL bp_commit got done=%0d lat=%0d want done=1 lat=1", nd, lt); end
    for (int v = 0; v < 8; v++) begin
      {left_i, up_i, down_i} = 5'($urandom); #1;
      total++; if (obs !== model_route(model_cfg, left_i, up_i, down_i)) begin bad++;
        $display("FAIL bp_routing got=%b want=%b", obs, model_route(model_cfg, left_i, up_i, down_i)); end
    end
  endtask

  task automatic test_random;
    int nd, ne, na, cy, lt;
    logic [11:0] c;
    bit lg;
    for (int it = 0; it < 12; it++) begin
      c  = 12'($urandom_range(0, 4095));
      lg = model_legal(c);
      run_load(c[7:0], {4'($urandom), c[11:8]}, 2, nd, ne, na, cy, lt);
      if (lg) model_cfg = c;
      total++; if (na !== 2) begin bad++; $display("FAIL rand_words cfg=%h got acc=%0d want 2", c, na); end
      total++; if (nd !== int'(lg) || ne !== int'(!lg) || lt !== 1) begin bad++;
        $display("FAIL rand_commit cfg=%h got done=%0d err=%0d lat=%0d want done=%0d err=%0d lat=1", c, nd, ne, lt, lg, !lg); end
      for (int v = 0; v < 3; v++) begin
        {left_i, up_i, down_i} = 5'($urandom); #1;
        total++; if (obs !== model_route(model_cfg, left_i, up_i, down_i)) begin bad++;
          $display("FAIL rand_routing cfg=%h got=%b want=%b", c, obs, model_route(model_cfg, left_i, up_i, down_i)); end
      end
    end
  endtask

  task automatic test_abort;
    int pulses;
    cif.cfg_start = 1'b1;
    @(posedge clk); #1;
    cif.cfg_start = 1'b0;
    cif.cfg_valid = 1'b1; cif.cfg_data = 8'h1c;
    @(posedge clk); #1;
    cif.cfg_abort = 1'b1; cif.cfg_data = 8'h3f;
    @(posedge clk); #1;
    cif.cfg_abort = 1'b0; cif.cfg_valid = 1'b0;
    @(negedge clk);
    total++; if (cif.cfg_busy !== 1'b0 || cif.cfg_ready !== 1'b0) begin bad++;
      $display("FAIL abort_idle got busy=%b ready=%b want 0 0", cif.cfg_busy, cif.cfg_ready); end
    pulses = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      pulses += int'(cif.cfg_done) + int'(cif.cfg_err);
    end
    total++; if (pulses !== 0) begin bad++; $display("FAIL abort_pulses got=%0d want=0", pulses); end
    left_i = 3'b010; up_i = 1'b1; down_i = 1'b0; #1;
    total++; if (obs !== model_route(model_cfg, left_i, up_i, down_i)) begin bad++;
      $display("FAIL abort_routing got=%b want=%b", obs, model_route(model_cfg, left_i, up_i, down_i)); end
    @(posedge clk); #1;
  endtask

  task automatic test_async_reset;
    cif.cfg_start = 1'b1;
    @(posedge clk); #1;
    cif.cfg_start = 1'b0;
    cif.cfg_valid = 1'b1; cif.cfg_data = 8'h55;
    @(posedge clk); #2;
    left_i = 3'b011; up_i = 1'b1; down_i = 1'b1;
    rst_n = 1'b0; #1;
    model_cfg = '0;
    total++; if ({cif.cfg_ready, cif.cfg_busy, cif.cfg_done, cif.cfg_err} !== 4'b0000) begin bad++;
      $display("FAIL arst_status got=%b want=0000", {cif.cfg_ready, cif.cfg_busy, cif.cfg_done, cif.cfg_err}); end
    total++; if (obs !== {4'b0000, left_i}) begin bad++; $display("FAIL arst_routing got=%b want=%b", obs, {4'b0000, left_i}); end
    cif.cfg_valid = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1 {left_i, up_i, down_i} = 5'($urandom); #1;
    total++; if (obs !== model_route(model_cfg, left_i, up_i, down_i) || cif.cfg_busy !== 1'b0) begin bad++;
      $display("FAIL arst_after got=%b busy=%b want=%b busy=0", obs, cif.cfg_busy, model_route(model_cfg, left_i, up_i, down_i)); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_illegal();
    test_legal();
    test_back_to_back();
    test_abort();
    test_random();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
